// File: rtl/alu_issue_stage.sv
// ID->EX issue register for the RVX10 pipeline.
// Decodes opcode/funct3/funct7 into the 5-bit ALU control code, picks operand B,
// and holds the op in a single registered slot behind a valid/ready handshake
// with stall and flush. Undecodable ops still flow, flagged illegal with code 00000.
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_alucontrol,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [RD_W-1:0] out_rd,
  output logic            out_illegal
);

  // Opcodes the stage recognises
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_CUST   = 7'b0001011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // ALU control codes, exactly as the execute stage decodes them
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SLT  = 5'b00101;
  localparam logic [4:0] ALU_SLL  = 5'b00110;
  localparam logic [4:0] ALU_SRL  = 5'b00111;
  localparam logic [4:0] ALU_ANDN = 5'b01000;
  localparam logic [4:0] ALU_ORN  = 5'b01001;
  localparam logic [4:0] ALU_XNOR = 5'b01010;
  localparam logic [4:0] ALU_MIN  = 5'b01011;
  localparam logic [4:0] ALU_MAX  = 5'b01100;
  localparam logic [4:0] ALU_MINU = 5'b01101;
  localparam logic [4:0] ALU_MAXU = 5'b01110;
  localparam logic [4:0] ALU_ROL  = 5'b01111;
  localparam logic [4:0] ALU_ROR  = 5'b10000;
  localparam logic [4:0] ALU_ABS  = 5'b10001;

  typedef struct packed {
    logic       illegal;
    logic [4:0] code;
  } dec_t;

  // Pure decode of the control fields; an illegal result always carries code 00000
  function automatic dec_t decode_op(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7);
    dec_t r;
    r.illegal = 1'b0;
    r.code    = ALU_ADD;
    case (op)
      OP_R: begin
        if (f7 == 7'b0100000) begin
          if (f3 == 3'b000) begin
            r.code = ALU_SUB;
          end else begin
            r.illegal = 1'b1;
          end
        end else if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  r.code = ALU_ADD;
            3'b001:  r.code = ALU_SLL;
            3'b010:  r.code = ALU_SLT;
            3'b100:  r.code = ALU_XOR;
            3'b101:  r.code = ALU_SRL;
            3'b110:  r.code = ALU_OR;
            3'b111:  r.code = ALU_AND;
            default: r.illegal = 1'b1;
          endcase
        end else begin
          r.illegal = 1'b1;
        end
      end
      OP_I: begin
        // funct7 is immediate bits except for the shifts, where it must be zero
        case (f3)
          3'b000:  r.code = ALU_ADD;
          3'b010:  r.code = ALU_SLT;
          3'b100:  r.code = ALU_XOR;
          3'b110:  r.code = ALU_OR;
          3'b111:  r.code = ALU_AND;
          3'b001: begin
            if (f7 == 7'b0000000) begin
              r.code = ALU_SLL;
            end else begin
              r.illegal = 1'b1;
            end
          end
          3'b101: begin
            if (f7 == 7'b0000000) begin
              r.code = ALU_SRL;
            end else begin
              r.illegal = 1'b1;
            end
          end
          default: r.illegal = 1'b1;
        endcase
      end
      OP_CUST: begin
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000:  r.code = ALU_ANDN;
              3'b001:  r.code = ALU_ORN;
              3'b010:  r.code = ALU_XNOR;
              default: r.illegal = 1'b1;
            endcase
          end
          7'b0000001: begin
            case (f3)
              3'b000:  r.code = ALU_MIN;
              3'b001:  r.code = ALU_MAX;
              3'b010:  r.code = ALU_MINU;
              3'b011:  r.code = ALU_MAXU;
              default: r.illegal = 1'b1;
            endcase
          end
          7'b0000010: begin
            case (f3)
              3'b000:  r.code = ALU_ROL;
              3'b001:  r.code = ALU_ROR;
              default: r.illegal = 1'b1;
            endcase
          end
          7'b0000011: begin
            // ABS is unary; the rs2 field is don't-care
            if (f3 == 3'b000) begin
              r.code = ALU_ABS;
            end else begin
              r.illegal = 1'b1;
            end
          end
          default: r.illegal = 1'b1;
        endcase
      end
      OP_LOAD, OP_STORE, OP_LUI, OP_JAL, OP_JALR: r.code = ALU_ADD;
      OP_BRANCH: r.code = ALU_SUB;
      default:   r.illegal = 1'b1;
    endcase
    if (r.illegal) begin
      r.code = ALU_ADD;
    end else begin
      r.code = r.code;
    end
    return r;
  endfunction

  logic            valid_q, valid_d;
  logic [4:0]      code_q, code_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            ill_q, ill_d;

  logic            capture_s;
  logic            fire_s;
  logic            use_imm_s;
  dec_t            dec_s;
  logic            unused_rs_fields_s;

  // Register-source index fields are not needed here; operands arrive already read
  assign unused_rs_fields_s = ^in_instr[24:15];

  // Handshake: single entry, so a new op is accepted only if the slot empties this edge
  assign in_ready  = !valid_q | out_ready;
  assign fire_s    = valid_q & out_ready;
  assign capture_s = in_valid & in_ready & !flush;

  // Decode and operand-B selection for the op offered this cycle
  always_comb begin
    dec_s     = decode_op(in_instr[6:0], in_instr[14:12], in_instr[31:25]);
    use_imm_s = 1'b0;
    case (in_instr[6:0])
      OP_I, OP_LOAD, OP_STORE: use_imm_s = 1'b1;
      default:                 use_imm_s = 1'b0;
    endcase
  end

  // Next-state for the issue slot: flush wins, then capture, then drain on fire
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    ill_d   = ill_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture_s) begin
      valid_d = 1'b1;
      code_d  = dec_s.code;
      a_d     = in_rs1_data;
      b_d     = use_imm_s ? in_imm : in_rs2_data;
      rd_d    = in_instr[7 +: RD_W];
      ill_d   = dec_s.illegal;
    end else if (fire_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Issue slot registers; asynchronous reset drops any held op immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      code_q  <= 5'b00000;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_alucontrol = code_q;
  assign out_a          = a_q;
  assign out_b          = b_q;
  assign out_rd         = rd_q;
  assign out_illegal    = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: a rule-table decoder and a queue of
// in-flight ops predict every cycle's handshake and registered outputs.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_alucontrol;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  typedef struct {
    logic [4:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    bit         f3_any;
    logic [6:0] f7;
    bit         f7_any;
    logic [4:0] code;
  } rule_t;

  rule_t rules[$];
  exp_t  exp_q[$];

  alu_issue_stage #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_alucontrol(out_alucontrol),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_rule(input logic [6:0] op, input logic [2:0] f3, input bit f3a,
                          input logic [6:0] f7, input bit f7a, input logic [4:0] code);
    rule_t r;
    r.op = op; r.f3 = f3; r.f3_any = f3a; r.f7 = f7; r.f7_any = f7a; r.code = code;
    rules.push_back(r);
  endtask

  // Reference: first matching table rule wins, no match means illegal
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rs1,
                                      input logic [31:0] rs2, input logic [31:0] imm);
    exp_t e;
    logic [6:0] op;
    op    = ins[6:0];
    e.a   = rs1;
    e.rd  = ins[11:7];
    e.b   = (op == 7'h13 || op == 7'h03 || op == 7'h23) ? imm : rs2;
    e.ill = 1'b1;
    e.code = 5'd0;
    foreach (rules[i]) begin
      if (e.ill && rules[i].op == op &&
          (rules[i].f3_any || rules[i].f3 == ins[14:12]) &&
          (rules[i].f7_any || rules[i].f7 == ins[31:25])) begin
        e.ill  = 1'b0;
        e.code = rules[i].code;
      end
    end
    return e;
  endfunction

  task automatic set_op(input logic [31:0] ins);
    in_instr    = ins;
    in_rs1_data = $urandom;
    in_rs2_data = $urandom;
    in_imm      = $urandom;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [6:0] op);
    logic [4:0] rs2, rs1, rd;
    rs2 = 5'($urandom); rs1 = 5'($urandom); rd = 5'($urandom);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [6:0] f7s [6];
    logic [6:0] op, f7;
    ops = '{7'h33, 7'h13, 7'h0B, 7'h0B, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h67};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h02, 7'h03, 7'h00};
    op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
    f7 = ($urandom_range(0, 7) == 0) ? 7'($urandom) : f7s[$urandom_range(0, 5)];
    return mk(f7, 3'($urandom_range(0, 7)), op);
  endfunction

  // One clock: check at negedge against the model, then advance the model at posedge
  task automatic step();
    bit   exp_v, exp_rdy, fire, cap;
    exp_t ent;
    @(negedge clk);
    exp_v   = (exp_q.size() != 0);
    exp_rdy = !exp_v || out_ready;
    check_eq("out_valid", 32'(out_valid), 32'(exp_v));
    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (exp_v) begin
      check_eq("alucontrol", 32'(out_alucontrol), 32'(exp_q[0].code));
      check_eq("out_a", out_a, exp_q[0].a);
      check_eq("out_b", out_b, exp_q[0].b);
      check_eq("out_rd", 32'(out_rd), 32'(exp_q[0].rd));
      check_eq("illegal", 32'(out_illegal), 32'(exp_q[0].ill));
    end
    if (out_valid) vcount++;
    fire = exp_v && out_ready;
    cap  = in_valid && exp_rdy && !flush;
    ent  = ref_decode(in_instr, in_rs1_data, in_rs2_data, in_imm);
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
    end else begin
      if (fire) void'(exp_q.pop_front());
      if (cap) exp_q.push_back(ent);
    end
    #1;
  endtask

  initial begin
    logic [31:0] ill_ops [4];
    logic [31:0] ins;

    // R-type
    add_rule(7'h33, 3'd0, 1'b0, 7'h00, 1'b0, 5'd0);
    add_rule(7'h33, 3'd0, 1'b0, 7'h20, 1'b0, 5'd1);
    add_rule(7'h33, 3'd7, 1'b0, 7'h00, 1'b0, 5'd2);
    add_rule(7'h33, 3'd6, 1'b0, 7'h00, 1'b0, 5'd3);
    add_rule(7'h33, 3'd4, 1'b0, 7'h00, 1'b0, 5'd4);
    add_rule(7'h33, 3'd2, 1'b0, 7'h00, 1'b0, 5'd5);
    add_rule(7'h33, 3'd1, 1'b0, 7'h00, 1'b0, 5'd6);
    add_rule(7'h33, 3'd5, 1'b0, 7'h00, 1'b0, 5'd7);
    // I-type
    add_rule(7'h13, 3'd0, 1'b0, 7'h00, 1'b1, 5'd0);
    add_rule(7'h13, 3'd7, 1'b0, 7'h00, 1'b1, 5'd2);
    add_rule(7'h13, 3'd6, 1'b0, 7'h00, 1'b1, 5'd3);
    add_rule(7'h13, 3'd4, 1'b0, 7'h00, 1'b1, 5'd4);
    add_rule(7'h13, 3'd2, 1'b0, 7'h00, 1'b1, 5'd5);
    add_rule(7'h13, 3'd1, 1'b0, 7'h00, 1'b0, 5'd6);
    add_rule(7'h13, 3'd5, 1'b0, 7'h00, 1'b0, 5'd7);
    // RVX10 custom
    add_rule(7'h0B, 3'd0, 1'b0, 7'h00, 1'b0, 5'd8);
    add_rule(7'h0B, 3'd1, 1'b0, 7'h00, 1'b0, 5'd9);
    add_rule(7'h0B, 3'd2, 1'b0, 7'h00, 1'b0, 5'd10);
    add_rule(7'h0B, 3'd0, 1'b0, 7'h01, 1'b0, 5'd11);
    add_rule(7'h0B, 3'd1, 1'b0, 7'h01, 1'b0, 5'd12);
    add_rule(7'h0B, 3'd2, 1'b0, 7'h01, 1'b0, 5'd13);
    add_rule(7'h0B, 3'd3, 1'b0, 7'h01, 1'b0, 5'd14);
    add_rule(7'h0B, 3'd0, 1'b0, 7'h02, 1'b0, 5'd15);
    add_rule(7'h0B, 3'd1, 1'b0, 7'h02, 1'b0, 5'd16);
    add_rule(7'h0B, 3'd0, 1'b0, 7'h03, 1'b0, 5'd17);
    // Memory, branch, upper/jump
    add_rule(7'h03, 3'd0, 1'b1, 7'h00, 1'b1, 5'd0);
    add_rule(7'h23, 3'd0, 1'b1, 7'h00, 1'b1, 5'd0);
    add_rule(7'h63, 3'd0, 1'b1, 7'h00, 1'b1, 5'd1);
    add_rule(7'h37, 3'd0, 1'b1, 7'h00, 1'b1, 5'd0);
    add_rule(7'h6F, 3'd0, 1'b1, 7'h00, 1'b1, 5'd0);
    add_rule(7'h67, 3'd0, 1'b1, 7'h00, 1'b1, 5'd0);

    // Reset state
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_op(32'h0000_0000);
    #3;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_code", 32'(out_alucontrol), 32'd0);
    check_eq("rst_a", out_a, 32'd0);
    check_eq("rst_b", out_b, 32'd0);
    check_eq("rst_rd", 32'(out_rd), 32'd0);
    check_eq("rst_ill", 32'(out_illegal), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    #9 reset_n = 1'b1;
    @(posedge clk); #1;

    // Decode sweep over every table encoding
    in_valid = 1'b1; out_ready = 1'b1;
    foreach (rules[i]) begin
      ins = mk(rules[i].f7_any ? 7'($urandom) : rules[i].f7,
               rules[i].f3_any ? 3'($urandom) : rules[i].f3, rules[i].op);
      set_op(ins);
      step();
    end
    // MAX x1,x1,x2
    set_op(32'h0220_908B);
    step();
    check_eq("max_code", 32'(out_alucontrol), 32'h0C);
    check_eq("max_rd", 32'(out_rd), 32'd1);
    check_eq("max_b", out_b, in_rs2_data);

    // Illegal encodings
    ill_ops[0] = {7'h01, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33};
    ill_ops[1] = {7'h00, 5'd2, 5'd1, 3'b011, 5'd3, 7'h0B};
    ill_ops[2] = {7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'h7F};
    ill_ops[3] = {7'h01, 5'd2, 5'd1, 3'b001, 5'd3, 7'h13};
    foreach (ill_ops[i]) begin
      set_op(ill_ops[i]);
      step();
      check_eq("ill_flag", 32'(out_illegal), 32'd1);
      check_eq("ill_code", 32'(out_alucontrol), 32'd0);
    end
    in_valid = 1'b0;
    step();

    // Back-pressure: 3 stalled cycles, then release captures the waiting op
    in_valid = 1'b1; set_op(rand_instr());
    step();
    out_ready = 1'b0; set_op(rand_instr());
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b1;
    step();
    check_eq("bp_capture", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();

    // Full throughput: 10 back-to-back ops
    vcount = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_op(rand_instr());
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check_eq("thru_fires", 32'(vcount), 32'd10);

    // Flush during a stall with an op offered
    in_valid = 1'b1; out_ready = 1'b1; set_op(rand_instr());
    step();
    out_ready = 1'b0; flush = 1'b1; set_op(rand_instr());
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_valid", 32'(out_valid), 32'd0);
    check_eq("flush_ready", 32'(in_ready), 32'd1);
    step();

    // Random stream
    for (int i = 0; i < 200; i++) begin
      in_valid  = ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      set_op(rand_instr());
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();

    // Reset mid-cycle while an op is held under stall
    in_valid = 1'b1; out_ready = 1'b0; set_op(rand_instr());
    step();
    check_eq("pre_rst_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    #2 reset_n = 1'b0;
    #1;
    check_eq("mrst_valid", 32'(out_valid), 32'd0);
    check_eq("mrst_code", 32'(out_alucontrol), 32'd0);
    check_eq("mrst_a", out_a, 32'd0);
    check_eq("mrst_b", out_b, 32'd0);
    check_eq("mrst_rd", 32'(out_rd), 32'd0);
    check_eq("mrst_ill", 32'(out_illegal), 32'd0);
    check_eq("mrst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    in_valid = 1'b0;
    #1 reset_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
